// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
//   div_state_t : controller states
//   DIV_WIDTH   : operand / quotient width
//   CNT_W       : iteration counter width (must hold the value DIV_WIDTH)
//   abs_val()   : two's-complement magnitude as an unsigned value
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The most negative value maps to 2^(W-1), which still fits because the
    // result is treated as unsigned.
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic signed [DIV_WIDTH-1:0] v);
        logic [DIV_WIDTH-1:0] mag;
        mag = v[DIV_WIDTH-1] ? DIV_WIDTH'(-v) : DIV_WIDTH'(v);
        return mag;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration, purely combinational.
//   r, q, m         : partial remainder, dividend/quotient shift register, divisor magnitude
//   r_next, q_next  : values after shifting {r,q} left and trying r - m
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] trial;

    always_comb begin
        // The bit leaving q enters the bottom of the remainder; the extra top
        // bit keeps the subtraction's sign visible.
        r_shift = {r, q[WIDTH-1]};
        trial   = r_shift - {1'b0, m};
        if (!trial[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            r_next = r_shift[WIDTH-1:0];
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_32.sv
// Sequential signed divider, one quotient bit per clock, fixed WIDTH-cycle
// latency from the last ctrl_DIV edge. Shares the mult_32 handshake.
//   clk, reset_n     : clock, asynchronous active-low reset
//   ctrl_DIV         : start strobe; restarts any operation in flight
//   dividend/divisor : signed operands, sampled only with ctrl_DIV
//   data_result      : signed quotient (truncated toward zero)
//   data_exception   : divide-by-zero or overflow
//   data_resultRDY   : result valid, held until the next start or reset
module div_32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state, state_next;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] r_reg, q_reg, m_reg;
    logic [WIDTH-1:0] r_next, q_next;
    logic             neg, dz, ovf;
    logic             last_step;
    logic [WIDTH-1:0] result_sel;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .m      (m_reg),
        .r_next (r_next),
        .q_next (q_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        last_step  = 1'b0;
        case (state)
            BUSY: begin
                if (counter == LAST_CNT) begin
                    state_next = DONE;
                    last_step  = 1'b1;
                end
            end
            default: ;
        endcase
        // A start strobe wins over everything, including the final step.
        if (ctrl_DIV) begin
            state_next = BUSY;
            last_step  = 1'b0;
        end
    end

    // Selection uses q_next so the result lands on the same edge as the
    // final quotient bit.
    always_comb begin
        result_sel = neg ? WIDTH'(-q_next) : q_next;
        if (dz)       result_sel = '0;
        else if (ovf) result_sel = MIN_NEG;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter        <= '0;
            r_reg          <= '0;
            q_reg          <= '0;
            m_reg          <= '0;
            neg            <= 1'b0;
            dz             <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (ctrl_DIV) begin
            q_reg          <= abs_val(dividend);
            m_reg          <= abs_val(divisor);
            r_reg          <= '0;
            neg            <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            dz             <= (divisor == '0);
            ovf            <= (dividend == MIN_NEG) && (divisor == '1);
            counter        <= '0;
            data_resultRDY <= 1'b0;
        end else if (state == BUSY) begin
            r_reg   <= r_next;
            q_reg   <= q_next;
            counter <= counter + CNT_W'(1);
            if (last_step) begin
                data_result    <= result_sel;
                data_exception <= dz | ovf;
                data_resultRDY <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_32.sv
module tb_div_32;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         ctrl_DIV;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;

    int n_checks = 0;
    int n_errors = 0;

    div_32 dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .dividend       (dividend),
        .divisor        (divisor),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed arithmetic, with the two exception cases.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] res, output logic exc);
        longint qa;
        if (b == 0) begin
            res = '0;
            exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            qa  = longint'($signed(a)) / longint'($signed(b));
            res = qa[W-1:0];
            exc = 1'b0;
        end
    endtask

    // Drives one start edge (E0) and releases the strobe just after it.
    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        ctrl_DIV = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        ctrl_DIV = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Called #1 after E0; result must appear exactly W edges later.
    task automatic wait_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] exp_res;
        logic         exp_exc;
        logic         early;
        ref_div(a, b, exp_res, exp_exc);
        early = 1'b0;
        for (int i = 1; i <= W; i++) begin
            @(posedge clk);
            #1;
            if (i < W && data_resultRDY) early = 1'b1;
            if (i % 7 == 0) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
        end
        check({tag, "_rdy_early"}, W'(early), '0);
        check({tag, "_rdy"}, W'(data_resultRDY), W'(1));
        check({tag, "_res"}, data_result, exp_res);
        check({tag, "_exc"}, W'(data_exception), W'(exp_exc));
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        start_div(a, b);
        wait_result(tag, a, b);
    endtask

    typedef struct {
        string        tag;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [W-1:0] ra, rb;
        logic         seen;

        reset_n  = 1'b0;
        ctrl_DIV = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("reset_res", data_result, '0);
        check("reset_exc", W'(data_exception), '0);
        check("reset_rdy", W'(data_resultRDY), '0);
        @(negedge clk);
        reset_n = 1'b1;

        vecs.push_back('{"35_7",     32'd35,          32'd7});
        vecs.push_back('{"m30_3",    -32'sd30,        32'd3});
        vecs.push_back('{"7_m2",     32'd7,           -32'sd2});
        vecs.push_back('{"m7_m2",    -32'sd7,         -32'sd2});
        vecs.push_back('{"3_10",     32'd3,           32'd10});
        vecs.push_back('{"100_0",    32'd100,         32'd0});
        vecs.push_back('{"min_m1",   32'h8000_0000,   32'hFFFF_FFFF});
        vecs.push_back('{"min_1",    32'h8000_0000,   32'd1});
        vecs.push_back('{"max_max",  32'h7FFF_FFFF,   32'h7FFF_FFFF});
        vecs.push_back('{"min_min",  32'h8000_0000,   32'h8000_0000});
        vecs.push_back('{"max_min",  32'h7FFF_FFFF,   32'h8000_0000});
        vecs.push_back('{"m1_0",     32'hFFFF_FFFF,   32'd0});
        foreach (vecs[i]) run_div(vecs[i].tag, vecs[i].a, vecs[i].b);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = W'($signed($urandom_range(0, 20)) - 10);
                default: rb = W'($signed($urandom) >>> $urandom_range(0, 31));
            endcase
            run_div("rand", ra, rb);
        end

        // Restart mid-operation: the aborted divide must never report.
        start_div(32'd1000, 32'd10);
        seen = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (data_resultRDY) seen = 1'b1;
        end
        start_div(32'd81, 32'd9);
        check("restart_rdy_gap", W'(seen), '0);
        wait_result("restart", 32'd81, 32'd9);

        // ctrl_DIV held for several edges: latency runs from the last one.
        @(negedge clk);
        ctrl_DIV = 1'b1;
        dividend = 32'd20;
        divisor  = 32'd3;
        @(posedge clk);
        @(negedge clk);
        dividend = -32'sd50;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        ctrl_DIV = 1'b0;
        wait_result("held", -32'sd50, 32'd7);

        // Asynchronous reset between edges in the middle of a divide.
        start_div(32'd500, 32'd5);
        for (int i = 1; i < 15; i++) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_res", data_result, '0);
        check("arst_exc", W'(data_exception), '0);
        check("arst_rdy", W'(data_resultRDY), '0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (data_resultRDY) seen = 1'b1;
        end
        check("post_reset_rdy", W'(seen), '0);
        run_div("after_reset", -32'sd99, 32'd4);

        // Result holds while operands wander and no strobe arrives.
        run_div("hold", 32'd64, 32'd8);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            dividend = $urandom;
            divisor  = $urandom;
            @(posedge clk);
            #1;
            check("hold_res", data_result, 32'd8);
            check("hold_rdy", W'(data_resultRDY), W'(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
